// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared constants for the sound-unit audio output stage
package sound_pkg;

    localparam int SAMPLE_W_DEF  = 20;
    localparam int SLOT_BITS_DEF = 32;
    localparam int FRAME_BITS    = 64;

    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

endpackage

// File: rtl/sound_pdm_mod.sv
// rtl/sound_pdm_mod.sv - first-order sigma-delta mono modulator (used with SOUND_I2S_PDM_EN)
module sound_pdm_mod
    import sound_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] left,
    input  logic [SAMPLE_W-1:0] right,
    output logic                pdm_out
);

    logic [SAMPLE_W-1:0] mono;
    logic [SAMPLE_W-1:0] acc;
    logic [SAMPLE_W:0]   acc_nxt;

    // floor((left+right)/2) without a wider intermediate sum
    always_comb begin
        mono    = (left >> 1) + (right >> 1) + SAMPLE_W'(left[0] & right[0]);
        acc_nxt = {1'b0, acc} + {1'b0, mono};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            pdm_out <= 1'b0;
        end else if (!enable) begin
            pdm_out <= 1'b0;
        end else begin
            acc     <= acc_nxt[SAMPLE_W-1:0];
            pdm_out <= acc_nxt[SAMPLE_W];
        end
    end

endmodule

// File: rtl/sound_i2s_tx.sv
// rtl/sound_i2s_tx.sv - Philips I2S transmitter for the sound unit's stereo mixer output
// Defining SOUND_I2S_PDM_EN adds the pdm_out sigma-delta mono output.
module sound_i2s_tx
    import sound_pkg::*;
#(
    parameter int BCLK_HALF = 1,
    parameter int SAMPLE_W  = SAMPLE_W_DEF,
    parameter int SLOT_BITS = SLOT_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] left,
    input  logic [SAMPLE_W-1:0] right,
    output logic                sample_strobe,
    output logic                i2s_bclk,
    output logic                i2s_lrck,
`ifdef SOUND_I2S_PDM_EN
    output logic                i2s_sdata,
    output logic                pdm_out
`else
    output logic                i2s_sdata
`endif
);

    localparam int FRAME = 2 * SLOT_BITS;
    localparam int CNT_W = $clog2(FRAME);
    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int IDX_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(FRAME - 2);
    localparam logic [CNT_W-1:0] CNT_SLOT  = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0] CNT_SW    = CNT_W'(SAMPLE_W);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [SAMPLE_W-1:0] left_q;
    logic [SAMPLE_W-1:0] right_q;

    logic                tick;
    logic [CNT_W-1:0]    bit_nxt;
    logic [CNT_W-1:0]    bit_ahead;
    logic [CNT_W-1:0]    slot_bit;
    logic                in_right;
    logic [SAMPLE_W-1:0] sel;
    logic                tx_bit;

    assign tick = (div_cnt == DIV_LAST);

    // bit_nxt is the frame position entered at this falling edge; lrck looks one bit ahead
    always_comb begin
        bit_nxt   = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
        bit_ahead = (bit_nxt == CNT_LAST) ? '0 : bit_nxt + 1'b1;
        in_right  = (bit_nxt >= CNT_SLOT);
        slot_bit  = in_right ? (bit_nxt - CNT_SLOT) : bit_nxt;
        sel       = in_right ? right_q : left_q;
        tx_bit    = 1'b0;
        if (slot_bit < CNT_SW) begin
            tx_bit = sel[IDX_W'(SAMPLE_W - 1) - IDX_W'(slot_bit)];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt       <= '0;
            bit_cnt       <= CNT_START;
            left_q        <= '0;
            right_q       <= '0;
            sample_strobe <= 1'b0;
            i2s_bclk      <= 1'b0;
            i2s_lrck      <= LRCK_LEFT;
            i2s_sdata     <= 1'b0;
        end else if (!enable) begin
            div_cnt       <= '0;
            bit_cnt       <= CNT_START;
            sample_strobe <= 1'b0;
            i2s_bclk      <= 1'b0;
            i2s_lrck      <= LRCK_LEFT;
            i2s_sdata     <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            if (tick) begin
                div_cnt  <= '0;
                i2s_bclk <= ~i2s_bclk;
                if (i2s_bclk) begin
                    bit_cnt   <= bit_nxt;
                    i2s_lrck  <= (bit_ahead >= CNT_SLOT) ? LRCK_RIGHT : LRCK_LEFT;
                    i2s_sdata <= tx_bit;
                    // Last bit of the frame: both channels of the next frame latch together
                    if (bit_nxt == CNT_LAST) begin
                        left_q        <= left;
                        right_q       <= right;
                        sample_strobe <= 1'b1;
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

`ifdef SOUND_I2S_PDM_EN
    sound_pdm_mod #(
        .SAMPLE_W (SAMPLE_W)
    ) u_pdm (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .left    (left_q),
        .right   (right_q),
        .pdm_out (pdm_out)
    );
`endif

endmodule

// File: tb/tb_sound_i2s_tx.sv
// tb/tb_sound_i2s_tx.sv - scoreboard bench for sound_i2s_tx
module tb_sound_i2s_tx;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [19:0] left;
    logic [19:0] right;
    logic        sample_strobe, i2s_bclk, i2s_lrck, i2s_sdata;
    logic        strobe2, bclk2, lrck2, sdata2;
    logic        pdm_out, pdm2;

    int n_vec = 0;
    int n_err = 0;

    sound_i2s_tx #(.BCLK_HALF(1), .SAMPLE_W(20), .SLOT_BITS(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .left(left), .right(right),
        .sample_strobe(sample_strobe), .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck),
`ifdef SOUND_I2S_PDM_EN
        .i2s_sdata(i2s_sdata), .pdm_out(pdm_out)
`else
        .i2s_sdata(i2s_sdata)
`endif
    );

    sound_i2s_tx #(.BCLK_HALF(2), .SAMPLE_W(20), .SLOT_BITS(32)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .left(left), .right(right),
        .sample_strobe(strobe2), .i2s_bclk(bclk2), .i2s_lrck(lrck2),
`ifdef SOUND_I2S_PDM_EN
        .i2s_sdata(sdata2), .pdm_out(pdm2)
`else
        .i2s_sdata(sdata2)
`endif
    );

`ifndef SOUND_I2S_PDM_EN
    assign pdm_out = 1'b0;
    assign pdm2    = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: expected samples captured at each latch, received frames from an I2S receiver model
    logic [39:0] exp_q[$];
    logic [63:0] rx_d_q[$];
    logic [63:0] rx_l_q[$];
    logic [19:0] lat_l, lat_r;
    logic [63:0] mon_d, mon_l;
    int          mon_cnt;
    bit          mon_active = 0;
    logic        bclk_prev = 0;

    always @(posedge clk) begin
        lat_l <= left;
        lat_r <= right;
    end

    always @(negedge clk) begin
        if (rst || !enable) begin
            mon_active = 0;
            mon_cnt    = 0;
        end else if (sample_strobe) begin
            exp_q.push_back({lat_l, lat_r});
            if (!mon_active) begin
                mon_active = 1;
                mon_cnt    = -1;
            end
        end else if (mon_active && i2s_bclk && !bclk_prev) begin
            if (mon_cnt >= 0) begin
                mon_d = {i2s_sdata, mon_d[63:1]};
                mon_l = {i2s_lrck, mon_l[63:1]};
            end
            mon_cnt++;
            if (mon_cnt == 64) begin
                rx_d_q.push_back(mon_d);
                rx_l_q.push_back(mon_l);
                mon_cnt = 0;
            end
        end
        bclk_prev = i2s_bclk;
    end

    function automatic logic [63:0] model_frame(input logic [19:0] l, input logic [19:0] r);
        logic [63:0] f;
        logic [19:0] s, t;
        int k;
        f = '0;
        for (int c = 0; c < 64; c++) begin
            k = c % 32;
            s = (c < 32) ? l : r;
            t = s >> (19 - k);
            f = {((k < 20) ? t[0] : 1'b0), f[63:1]};
        end
        return f;
    endfunction

    function automatic logic [63:0] model_lrck();
        logic [63:0] f;
        f = '0;
        for (int c = 0; c < 64; c++) f = {((c >= 31 && c <= 62) ? 1'b1 : 1'b0), f[63:1]};
        return f;
    endfunction

    function automatic logic [19:0] rx_left(input logic [63:0] d);
        logic [19:0] l;
        logic [63:0] t;
        t = d;
        l = '0;
        for (int k = 0; k < 20; k++) begin
            l = {l[18:0], t[0]};
            t = t >> 1;
        end
        return l;
    endfunction

    task automatic pop_frame(output logic [63:0] d, output logic [63:0] lr,
                             output logic [39:0] e, output bit ok);
        ok = 0;
        d = '0; lr = '0; e = '0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk); #1;
            if (rx_d_q.size() > 0 && exp_q.size() > 0) begin
                d  = rx_d_q.pop_front();
                lr = rx_l_q.pop_front();
                e  = exp_q.pop_front();
                ok = 1;
            end
        end
    endtask

    task automatic wait_strobe(input bit use2, input int bound, output int cnt, output bit ok);
        ok  = 0;
        cnt = 0;
        while (!ok && cnt < bound) begin
            @(posedge clk); #1;
            cnt++;
            if ((use2 ? strobe2 : sample_strobe) === 1'b1) ok = 1;
        end
    endtask

    task automatic start_stream(input logic [19:0] l, input logic [19:0] r);
        @(posedge clk); #2;
        enable = 1'b0;
        @(negedge clk); #1;
        exp_q.delete(); rx_d_q.delete(); rx_l_q.delete();
        left  = l;
        right = r;
        @(posedge clk); #2;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; left = '0; right = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({i2s_bclk, i2s_lrck, i2s_sdata, sample_strobe} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs got %b want 0000", {i2s_bclk, i2s_lrck, i2s_sdata, sample_strobe});
        end
        n_vec++;
        if ({bclk2, lrck2, sdata2, strobe2, pdm_out} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_outputs2 got %b want 00000", {bclk2, lrck2, sdata2, strobe2, pdm_out});
        end
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic test_bit_order();
        logic [63:0] d, lr;
        logic [39:0] e;
        bit ok;
        start_stream(20'h80001, 20'h00003);
        for (int f = 0; f < 2; f++) begin
            pop_frame(d, lr, e, ok);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL bit_order_timeout frame %0d got none want frame", f);
            end else begin
                n_vec++;
                if (d !== 64'h000C_0000_0008_0001) begin
                    n_err++;
                    $display("FAIL bit_order_data got %h want %h", d, 64'h000C_0000_0008_0001);
                end
                n_vec++;
                if (d !== model_frame(e[39:20], e[19:0])) begin
                    n_err++;
                    $display("FAIL bit_order_sb got %h want %h", d, model_frame(e[39:20], e[19:0]));
                end
                n_vec++;
                if (lr !== 64'h7FFF_FFFF_8000_0000) begin
                    n_err++;
                    $display("FAIL bit_order_lrck got %h want %h", lr, 64'h7FFF_FFFF_8000_0000);
                end
            end
        end
    endtask

    task automatic test_mid_frame();
        logic [63:0] d, lr;
        logic [39:0] e;
        logic [19:0] want_l;
        bit ok;
        int cnt;
        start_stream(20'h12345, 20'h0ABCD);
        wait_strobe(0, 20, cnt, ok);
        repeat (70) @(posedge clk);
        #2;
        left = 20'h5A5A5;
        for (int f = 0; f < 2; f++) begin
            want_l = (f == 0) ? 20'h12345 : 20'h5A5A5;
            pop_frame(d, lr, e, ok);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL mid_frame_timeout frame %0d got none want frame", f);
            end else begin
                n_vec++;
                if (rx_left(d) !== want_l) begin
                    n_err++;
                    $display("FAIL mid_frame_left frame %0d got %h want %h", f, rx_left(d), want_l);
                end
                n_vec++;
                if (d !== model_frame(e[39:20], e[19:0]) || lr !== model_lrck()) begin
                    n_err++;
                    $display("FAIL mid_frame_sb frame %0d got %h want %h", f, d, model_frame(e[39:20], e[19:0]));
                end
            end
        end
    endtask

    task automatic test_enable_toggle();
        logic [63:0] d, lr;
        logic [39:0] e;
        bit ok;
        int cnt;
        start_stream(20'hFFFFF, 20'hFFFFF);
        wait_strobe(0, 20, cnt, ok);
        repeat (82) @(posedge clk);
        #1;
        n_vec++;
        if (i2s_lrck !== 1'b1) begin
            n_err++;
            $display("FAIL toggle_lrck_bit40 got %b want 1", i2s_lrck);
        end
        enable = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({i2s_bclk, i2s_lrck, i2s_sdata, sample_strobe} !== 4'b0000) begin
            n_err++;
            $display("FAIL toggle_disable got %b want 0000", {i2s_bclk, i2s_lrck, i2s_sdata, sample_strobe});
        end
        @(negedge clk); #1;
        exp_q.delete(); rx_d_q.delete(); rx_l_q.delete();
        left = 20'h80000; right = 20'h00001;
        @(posedge clk); #2;
        enable = 1'b1;
        wait_strobe(0, 20, cnt, ok);
        n_vec++;
        if (!ok || cnt !== 2) begin
            n_err++;
            $display("FAIL toggle_strobe_delay got %0d want 2", cnt);
        end
        n_vec++;
        if (i2s_lrck !== 1'b0) begin
            n_err++;
            $display("FAIL toggle_lrck_at_strobe got %b want 0", i2s_lrck);
        end
        pop_frame(d, lr, e, ok);
        n_vec++;
        if (!ok || rx_left(d) !== 20'h80000 || d !== model_frame(e[39:20], e[19:0])) begin
            n_err++;
            $display("FAIL toggle_first_frame got %h want %h", d, model_frame(20'h80000, 20'h00001));
        end
    endtask

    task automatic test_frame_timing();
        bit ok, found;
        int cnt, hi, per;
        logic prev;
        start_stream(20'h0F0F0, 20'hF0F0F);
        wait_strobe(1, 20, cnt, ok);
        n_vec++;
        if (!ok || cnt !== 4) begin
            n_err++;
            $display("FAIL timing_first_strobe got %0d want 4", cnt);
        end
        hi = 0; cnt = 0; ok = 0;
        while (!ok && cnt < 600) begin
            @(posedge clk); #1;
            cnt++;
            if (strobe2 === 1'b1) ok = 1;
            else if (lrck2 === 1'b1) hi++;
        end
        n_vec++;
        if (!ok || cnt !== 256) begin
            n_err++;
            $display("FAIL timing_strobe_period got %0d want 256", cnt);
        end
        n_vec++;
        if (hi !== 128) begin
            n_err++;
            $display("FAIL timing_lrck_duty got %0d want 128", hi);
        end
        prev = bclk2; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (bclk2 && !prev) found = 1;
            prev = bclk2;
        end
        per = 0; found = 0;
        while (!found && per < 20) begin
            @(posedge clk); #1;
            per++;
            if (bclk2 && !prev) found = 1;
            prev = bclk2;
        end
        n_vec++;
        if (!found || per !== 4) begin
            n_err++;
            $display("FAIL timing_bclk_period got %0d want 4", per);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int cnt;
        start_stream(20'h12345, 20'hABCDE);
        wait_strobe(0, 20, cnt, ok);
        repeat (31) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({i2s_bclk, i2s_lrck, i2s_sdata, sample_strobe, bclk2, lrck2} !== 6'b000000) begin
            n_err++;
            $display("FAIL async_reset got %b want 000000",
                     {i2s_bclk, i2s_lrck, i2s_sdata, sample_strobe, bclk2, lrck2});
        end
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete(); rx_d_q.delete(); rx_l_q.delete();
        #1;
        rst = 1'b0;
        wait_strobe(0, 20, cnt, ok);
        n_vec++;
        if (!ok || cnt !== 2) begin
            n_err++;
            $display("FAIL reset_first_strobe got %0d want 2", cnt);
        end
    endtask

`ifdef SOUND_I2S_PDM_EN
    task automatic test_pdm();
        bit ok;
        int cnt, ones;
        start_stream(20'h40000, 20'h40000);
        wait_strobe(0, 20, cnt, ok);
        repeat (4) @(posedge clk);
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (pdm_out === 1'b1) ones++;
        end
        n_vec++;
        if (ones < 255 || ones > 257) begin
            n_err++;
            $display("FAIL pdm_density got %0d want 256+-1", ones);
        end
        start_stream(20'h0, 20'h0);
        wait_strobe(0, 20, cnt, ok);
        repeat (2) @(posedge clk);
        ones = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (pdm_out !== 1'b0) ones++;
        end
        n_vec++;
        if (ones !== 0) begin
            n_err++;
            $display("FAIL pdm_zero got %0d want 0", ones);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bit_order();
        test_mid_frame();
        test_enable_toggle();
        test_frame_timing();
        test_reset_mid_frame();
`ifdef SOUND_I2S_PDM_EN
        test_pdm();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
